// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int N_REQ_DEF = 4;
  localparam int DEPTH_DEF = 64;
  localparam int GNT_W     = $clog2(N_REQ_DEF);
  localparam int OCC_W     = $clog2(DEPTH_DEF) + 1;
  localparam int RR_MAX    = 8;

  // First valid index after last_ptr, wrapping modulo n; 0 when nothing is valid.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                 input int last_ptr,
                                 input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      idx = (last_ptr + k) % n;
      if (k <= n && !found && valid[idx[2:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_sel.sv
// Combinational round-robin priority picker over N_REQ valid lines.
`timescale 1ns/1ps
module rr_sel
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] last_ptr,
  output logic [$clog2(N_REQ)-1:0] pick,
  output logic                     any
);

  localparam int GW = $clog2(N_REQ);

  assign pick = GW'(rr_pick(RR_MAX'(valid), int'(last_ptr), N_REQ));
  assign any  = |valid;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo write port among N_REQ bursting producers;
// it tracks fifo occupancy itself so a full fifo is never written.
`timescale 1ns/1ps
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_MAX = 8,
  parameter int TMO       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_we,
  output logic [DATA_W-1:0]          fifo_wd,
  output logic [1:0]                 fifo_lvl,
  input  logic                       fifo_re,
  input  logic                       fifo_full,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int GW = $clog2(N_REQ);
  localparam int OW = $clog2(DEPTH) + 1;

  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] BURST = ST_BURST;

  logic [0:0]        state;
  logic [GW-1:0]     last_ptr;
  logic [7:0]        beat_cnt;
  logic [7:0]        tmo_cnt;
  logic [GW-1:0]     pick;
  logic              pick_any;
  logic              space;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              burst_end;
  logic              stall_idle;

  rr_sel #(
    .N_REQ(N_REQ)
  ) u_rr_sel (
    .valid    (req_valid),
    .last_ptr (last_ptr),
    .pick     (pick),
    .any      (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == grant) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign busy     = (state == BURST);
  assign space    = (occ < OW'(DEPTH)) && !fifo_full;
  assign fifo_we  = busy && space && sel_valid;
  assign fifo_wd  = busy ? sel_data : '0;
  assign fifo_lvl = 2'b11;

  // Only the grantee sees ready, and only while the fifo has room this cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (busy && space && GW'(i) == grant) req_ready[i] = 1'b1;
    end
  end

  assign burst_end  = fifo_we && (sel_last || beat_cnt == 8'(BURST_MAX - 1));
  assign stall_idle = busy && space && !sel_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      last_ptr <= GW'(N_REQ - 1);
      beat_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= pick;
            state    <= BURST;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
          end
        end
        BURST: begin
          if (fifo_we) begin
            beat_cnt <= beat_cnt + 8'd1;
            tmo_cnt  <= '0;
            if (burst_end) begin
              state    <= IDLE;
              last_ptr <= grant;
            end
          end else if (stall_idle) begin
            // A fifo-side stall (no space) never ages the grant.
            if (tmo_cnt == 8'(TMO - 1)) begin
              state    <= IDLE;
              last_ptr <= grant;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (fifo_we && !fifo_re) begin
      occ <= occ + OW'(1);
    end else if (fifo_re && !fifo_we && occ != '0) begin
      occ <= occ - OW'(1);
    end
  end

endmodule
